// File: rtl/exe_stage.sv
// Execute stage: registered operands feed a 12-op ALU with zero-cycle latency,
// plus a 32-cycle radix-2 shift-add multiplier that writes HI/LO on hand-off.

module alu (
    input  logic [11:0] i_alu_control,
    input  logic [31:0] i_src1,
    input  logic [31:0] i_src2,
    output logic [31:0] o_result
);
    logic        w_op_add, w_op_sub, w_op_slt, w_op_sltu;
    logic        w_op_and, w_op_nor, w_op_or,  w_op_xor;
    logic        w_op_sll, w_op_srl, w_op_sra, w_op_lui;
    logic [31:0] w_add_b;
    logic        w_cin;
    logic [31:0] w_sum;
    logic        w_cout;
    logic        w_slt;
    logic [4:0]  w_sa;

    assign {w_op_add, w_op_sub, w_op_slt, w_op_sltu,
            w_op_and, w_op_nor, w_op_or,  w_op_xor,
            w_op_sll, w_op_srl, w_op_sra, w_op_lui} = i_alu_control;

    // Subtract and both compares share one adder: a + ~b + 1.
    assign w_cin   = w_op_sub | w_op_slt | w_op_sltu;
    assign w_add_b = w_cin ? ~i_src2 : i_src2;
    assign {w_cout, w_sum} = {1'b0, i_src1} + {1'b0, w_add_b} + {32'd0, w_cin};

    assign w_slt = (i_src1[31] & ~i_src2[31]) | (~(i_src1[31] ^ i_src2[31]) & w_sum[31]);
    assign w_sa  = i_src1[4:0];

    assign o_result = ({32{w_op_add | w_op_sub}} & w_sum)
                    | ({32{w_op_slt}}  & {31'd0, w_slt})
                    | ({32{w_op_sltu}} & {31'd0, ~w_cout})
                    | ({32{w_op_and}}  & (i_src1 & i_src2))
                    | ({32{w_op_nor}}  & ~(i_src1 | i_src2))
                    | ({32{w_op_or}}   & (i_src1 | i_src2))
                    | ({32{w_op_xor}}  & (i_src1 ^ i_src2))
                    | ({32{w_op_sll}}  & (i_src2 << w_sa))
                    | ({32{w_op_srl}}  & (i_src2 >> w_sa))
                    | ({32{w_op_sra}}  & 32'($signed(i_src2) >>> w_sa))
                    | ({32{w_op_lui}}  & {i_src2[15:0], 16'd0});
endmodule

module exe_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        de_valid,
    output logic        exe_allowin,
    input  logic [11:0] de_alu_control,
    input  logic [31:0] de_src1,
    input  logic [31:0] de_src2,
    input  logic        de_check_ov,
    input  logic        de_mul,
    input  logic        de_mul_signed,
    input  logic [4:0]  de_dest,
    input  logic [31:0] de_pc,
    input  logic        flush,
    input  logic        mem_allowin,
    output logic        exe_to_mem_valid,
    output logic [31:0] exe_result,
    output logic [31:0] exe_pc,
    output logic [4:0]  exe_dest,
    output logic        exe_ov_ex,
    output logic [31:0] exe_hi,
    output logic [31:0] exe_lo,
    output logic        exe_hilo_we
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_t;

    logic        r_exe_valid;
    logic [11:0] r_alu_control;
    logic [31:0] r_src1, r_src2, r_pc;
    logic        r_check_ov, r_mul, r_mul_signed;
    logic [4:0]  r_dest;
    mul_state_t  r_state, w_next_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_prod;
    logic [31:0] r_hi, r_lo;

    logic        w_ready_go, w_load, w_handoff;
    logic        w_neg1, w_neg2;
    logic [31:0] w_mag1, w_mag2, w_ov_b;
    logic [63:0] w_partial, w_acc, w_final;

    assign w_ready_go       = ~r_mul | (r_state == S_DONE);
    assign exe_allowin      = ~r_exe_valid | (w_ready_go & mem_allowin);
    assign exe_to_mem_valid = r_exe_valid & w_ready_go;
    assign w_handoff        = w_ready_go & mem_allowin;
    assign w_load           = exe_allowin & de_valid & ~flush;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_exe_valid <= 1'b0;
        end else if (flush) begin
            r_exe_valid <= 1'b0;
        end else if (exe_allowin) begin
            r_exe_valid <= de_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_alu_control <= '0;
            r_src1        <= '0;
            r_src2        <= '0;
            r_check_ov    <= 1'b0;
            r_mul         <= 1'b0;
            r_mul_signed  <= 1'b0;
            r_dest        <= '0;
            r_pc          <= '0;
        end else if (w_load) begin
            r_alu_control <= de_alu_control;
            r_src1        <= de_src1;
            r_src2        <= de_src2;
            r_check_ov    <= de_check_ov;
            r_mul         <= de_mul;
            r_mul_signed  <= de_mul_signed;
            r_dest        <= de_dest;
            r_pc          <= de_pc;
        end
    end

    alu u_alu (
        .i_alu_control (r_alu_control),
        .i_src1        (r_src1),
        .i_src2        (r_src2),
        .o_result      (exe_result)
    );

    assign w_ov_b    = r_alu_control[10] ? ~r_src2 : r_src2;
    assign exe_ov_ex = r_exe_valid & r_check_ov & (r_alu_control[11] | r_alu_control[10])
                     & (r_src1[31] == w_ov_b[31]) & (exe_result[31] != r_src1[31]);

    // The multiplier enters BUSY on the same edge that loads it, so cycles
    // T..T+31 each add one partial product and DONE is reached at T+32.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = S_IDLE;
        end else if (w_load && de_mul) begin
            w_next_state = S_BUSY;
        end else begin
            case (r_state)
                S_BUSY:  if (r_cnt == 5'd31) w_next_state = S_DONE;
                S_DONE:  if (w_handoff)      w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Magnitudes: -0x80000000 wraps to 0x80000000, which is exactly 2^31 unsigned.
    assign w_neg1    = r_mul_signed & r_src1[31];
    assign w_neg2    = r_mul_signed & r_src2[31];
    assign w_mag1    = w_neg1 ? -r_src1 : r_src1;
    assign w_mag2    = w_neg2 ? -r_src2 : r_src2;
    assign w_partial = w_mag2[r_cnt] ? ({32'd0, w_mag1} << r_cnt) : 64'd0;
    assign w_acc     = r_prod + w_partial;
    assign w_final   = (w_neg1 ^ w_neg2) ? -w_acc : w_acc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt  <= '0;
            r_prod <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else if (flush) begin
            r_cnt  <= '0;
        end else if (w_load && de_mul) begin
            r_cnt  <= '0;
            r_prod <= '0;
        end else if (r_state == S_BUSY) begin
            r_prod <= w_acc;
            r_cnt  <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
                r_hi <= w_final[63:32];
                r_lo <= w_final[31:0];
            end
        end
    end

    assign exe_hi      = r_hi;
    assign exe_lo      = r_lo;
    assign exe_hilo_we = exe_to_mem_valid & r_mul;
    assign exe_pc      = r_pc;
    assign exe_dest    = r_exe_valid ? r_dest : 5'd0;
endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL use one clock and reset; reset is asynchronous and active-low: clk, resetn.
REQ-002 clk  input  1  stage clock, all state on rising edge.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 de_valid  input  1  decode stage holds a valid instruction.
REQ-005 exe_allowin  output  1  stage accepts a new instruction this cycle.
REQ-006 de_alu_control  input  12  one-hot ALU op: add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui (bit 11..0).
REQ-007 de_src1, de_src2  input  32 each  operands; src1[4:0] is shift amount for shifts.
REQ-008 de_check_ov  input  1  signed add/sub, raise overflow exception.
REQ-009 de_mul, de_mul_signed  input  1 each  multiply to HI/LO; signed/unsigned.
REQ-010 de_dest  input  5  destination register, 0 = none.
REQ-011 de_pc  input  32  instruction PC.
REQ-012 flush  input  1  cancel instruction in stage.
REQ-013 mem_allowin  input  1  memory stage can accept.
REQ-014 exe_to_mem_valid  output  1  result valid toward memory stage.
REQ-015 exe_result, exe_pc  output  32 each  ALU result, registered PC.
REQ-016 exe_dest  output  5  registered destination, forced 0 when exe_valid=0 (bypass use).
REQ-017 exe_ov_ex  output  1  overflow exception.
REQ-018 exe_hi, exe_lo, exe_hilo_we  output  32,32,1  product and HI/LO write enable.

Function
REQ-019 exe_valid register SHALL load de_valid on edge when exe_allowin=1; operand/control registers load only when exe_allowin & de_valid.
REQ-020 exe_allowin = ~exe_valid | (ready_go & mem_allowin); exe_to_mem_valid = exe_valid & ready_go.
REQ-021 ready_go SHALL be 1 for non-mul ops; for mul ops, 1 only in DONE.
REQ-022 exe_result SHALL come combinationally from the team 12-op ALU instance on registered operands, zero-cycle latency.
REQ-023 exe_ov_ex = exe_valid & check_ov & (add|sub) & (src1[31]==b[31]) & (result[31]!=src1[31]), b = src2 for add, ~src2 for sub.
REQ-024 Multiplier FSM states IDLE, BUSY, DONE; IDLE->BUSY on edge after a mul instruction enters (cycle T), counter=0.
REQ-025 BUSY: radix-2 shift-add on |src1|,|src2| (magnitudes when signed), one bit per cycle, counter 0..31; BUSY->DONE after 32 iterations (DONE at T+32).
REQ-026 DONE: 64-bit product negated if signed and operand signs differ; exe_hi/exe_lo stable; DONE->IDLE on hand-off (ready_go & mem_allowin).
REQ-027 exe_hilo_we = exe_to_mem_valid & mul; exe_hi/exe_lo hold last product otherwise.
REQ-028 Unsigned mul SHALL treat 0x80000000 as 2^31; signed -2^31 * -2^31 = 0x40000000_00000000.
REQ-029 flush SHALL clear exe_valid and force FSM to IDLE on next edge, overriding any new load; no hilo_we from flushed op.
REQ-030 Back-pressure (mem_allowin=0) SHALL hold all registers and DONE state unchanged.
REQ-031 Back-to-back non-mul ops with mem_allowin=1 SHALL flow one per cycle.

Reset
REQ-032 On resetn=0, immediately: exe_valid=0, FSM=IDLE, counter=0, product/HI/LO=0, operand registers=0; hence exe_to_mem_valid=0, exe_hilo_we=0, exe_ov_ex=0, exe_dest=0, exe_allowin=1.
REQ-033 Reset during BUSY SHALL abandon the multiply; no HI/LO write after release.

Verification
REQ-034 add, check_ov=1, src1=0x7FFFFFFF, src2=1 -> exe_result 0x80000000, exe_ov_ex=1; same with check_ov=0 -> exe_ov_ex=0.
REQ-035 sub, check_ov=1, 0x80000000-1 -> result 0x7FFFFFFF, exe_ov_ex=1; slt 0xFFFFFFFF,1 -> 1; sltu same -> 0.
REQ-036 signed mul -3*5 entering at T -> exe_to_mem_valid first at T+32, hi=0xFFFFFFFF, lo=0xFFFFFFF1, hilo_we=1 one cycle; exe_allowin=0 for T..T+31.
REQ-037 unsigned mul 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-038 mem_allowin=0 for 5 cycles with valid or op -> outputs stable, exe_allowin=0; release -> accepted next op following cycle.
REQ-039 flush at T+10 of mul, then resetn pulse at T+5 of second mul -> exe_valid=0, FSM IDLE, no hilo_we either time.
